// File: rtl/pvt_sweep_ctrl.sv
// PVT sensor sweep sequencer: steps TS probes, VS channels and optional PS,
// handles settle/SOC/EOC handshakes and emits one indexed result per channel.
module pvt_sweep_ctrl #(
    parameter int unsigned NUM_TS_PROBES  = 1,
    parameter int unsigned NUM_VOL        = 14,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic        i_abort,
    input  logic [2:0]  i_ps_mode,
    output logic        o_busy,
    output logic        o_pvt_en_ts,
    output logic        o_pvt_en_adc_ts,
    output logic        o_pvt_soc_ts,
    output logic [5:0]  o_pvt_bjt_sel_ts,
    output logic [3:0]  o_pvt_sel_ts,
    output logic        o_pvt_soc_ps,
    output logic [2:0]  o_pvt_en_ps,
    input  logic        i_pvt_eoc_ts,
    input  logic        i_pvt_eoc_ps,
    input  logic [11:0] i_pvt_out_12bit_ts,
    input  logic [11:0] i_pvt_out_12bit_ps,
    output logic        o_res_valid,
    output logic [6:0]  o_res_idx,
    output logic [11:0] o_res_data,
    output logic        o_res_timeout,
    output logic        o_sweep_done
);

    localparam int unsigned IDX_W   = 7;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] PS_IDX       = IDX_W'(NUM_TS_PROBES + NUM_VOL);
    localparam logic [IDX_W-1:0] LAST_NO_PS   = IDX_W'(NUM_TS_PROBES + NUM_VOL - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SOC, S_WAIT_EOC, S_RESULT, S_DONE
    } state_t;

    typedef struct packed {
        logic [5:0] bjt_sel;
        logic [3:0] sel;
        logic [2:0] en_ps;
    } mux_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [2:0]       ps_mode;
    logic [CNT_W-1:0] cnt;
    logic             eoc_prev;

    logic             is_ps_c;
    logic             is_last_c;
    logic             eoc_c;
    logic [11:0]      data_c;
    logic             launch_c;
    logic [IDX_W-1:0] idx_next_c;

    // Mux settings for a channel index: TS probes, then VS channels, then PS.
    function automatic mux_t chan_mux(input logic [IDX_W-1:0] ch, input logic [2:0] mode);
        mux_t m;
        m = '0;
        if (ch < IDX_W'(NUM_TS_PROBES))
            m.bjt_sel = 6'(ch);
        else if (ch < PS_IDX)
            m.sel = 4'(ch - IDX_W'(NUM_TS_PROBES) + IDX_W'(1));
        else
            m.en_ps = mode;
        return m;
    endfunction

    assign is_ps_c    = (ps_mode != 3'd0) && (idx == PS_IDX);
    assign is_last_c  = (ps_mode != 3'd0) ? (idx == PS_IDX) : (idx == LAST_NO_PS);
    assign eoc_c      = is_ps_c ? i_pvt_eoc_ps : i_pvt_eoc_ts;
    assign data_c     = is_ps_c ? i_pvt_out_12bit_ps : i_pvt_out_12bit_ts;
    assign launch_c   = ((state == S_IDLE) && i_start) || ((state == S_DONE) && i_continuous);
    assign idx_next_c = idx + IDX_W'(1);

    // Sequencer with registered control, strobe and result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            idx              <= '0;
            ps_mode          <= '0;
            cnt              <= '0;
            eoc_prev         <= 1'b0;
            o_busy           <= 1'b0;
            o_pvt_en_ts      <= 1'b0;
            o_pvt_en_adc_ts  <= 1'b0;
            o_pvt_soc_ts     <= 1'b0;
            o_pvt_soc_ps     <= 1'b0;
            o_pvt_bjt_sel_ts <= '0;
            o_pvt_sel_ts     <= '0;
            o_pvt_en_ps      <= '0;
            o_res_valid      <= 1'b0;
            o_res_idx        <= '0;
            o_res_data       <= '0;
            o_res_timeout    <= 1'b0;
            o_sweep_done     <= 1'b0;
        end else begin
            o_pvt_soc_ts <= 1'b0;
            o_pvt_soc_ps <= 1'b0;
            o_res_valid  <= 1'b0;
            o_sweep_done <= 1'b0;
            if (i_abort) begin
                state            <= S_IDLE;
                idx              <= '0;
                cnt              <= '0;
                eoc_prev         <= 1'b0;
                o_busy           <= 1'b0;
                o_pvt_en_ts      <= 1'b0;
                o_pvt_en_adc_ts  <= 1'b0;
                o_pvt_bjt_sel_ts <= '0;
                o_pvt_sel_ts     <= '0;
                o_pvt_en_ps      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            state        <= S_SOC;
                            cnt          <= '0;
                            o_pvt_soc_ts <= !is_ps_c;
                            o_pvt_soc_ps <= is_ps_c;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_SOC: begin
                        // Baseline the EOC level so only a fresh rising edge counts.
                        state    <= S_WAIT_EOC;
                        cnt      <= '0;
                        eoc_prev <= eoc_c;
                    end
                    S_WAIT_EOC: begin
                        eoc_prev <= eoc_c;
                        if (eoc_c && !eoc_prev) begin
                            state         <= S_RESULT;
                            o_res_valid   <= 1'b1;
                            o_res_idx     <= idx;
                            o_res_data    <= data_c;
                            o_res_timeout <= 1'b0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state         <= S_RESULT;
                            o_res_valid   <= 1'b1;
                            o_res_idx     <= idx;
                            o_res_data    <= 12'h000;
                            o_res_timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_RESULT: begin
                        cnt <= '0;
                        if (is_last_c) begin
                            state        <= S_DONE;
                            o_sweep_done <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            idx   <= idx_next_c;
                            {o_pvt_bjt_sel_ts, o_pvt_sel_ts, o_pvt_en_ps} <= chan_mux(idx_next_c, ps_mode);
                        end
                    end
                    S_DONE: begin
                        state            <= S_IDLE;
                        o_busy           <= 1'b0;
                        o_pvt_en_ts      <= 1'b0;
                        o_pvt_en_adc_ts  <= 1'b0;
                        o_pvt_bjt_sel_ts <= '0;
                        o_pvt_sel_ts     <= '0;
                        o_pvt_en_ps      <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
                // New sweep from IDLE or back-to-back after DONE.
                if (launch_c) begin
                    state           <= S_SETTLE;
                    idx             <= '0;
                    ps_mode         <= i_ps_mode;
                    cnt             <= '0;
                    o_busy          <= 1'b1;
                    o_pvt_en_ts     <= 1'b1;
                    o_pvt_en_adc_ts <= 1'b1;
                    {o_pvt_bjt_sel_ts, o_pvt_sel_ts, o_pvt_en_ps} <= chan_mux('0, i_ps_mode);
                end
            end
        end
    end

endmodule

// File: tb/tb_pvt_sweep_ctrl.sv
// Randomized bench for pvt_sweep_ctrl: an emulated PVT wrapper answers each SOC and
// results are checked against a channel-list model built from the sweep rules.
module tb_pvt_sweep_ctrl;

    localparam int unsigned NUM_TS  = 1;
    localparam int unsigned NUM_VOL = 14;
    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 4096;

    typedef struct {
        int idx;
        int bjt;
        int sel;
        int en_ps;
        bit ps;
    } chan_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic        abort_req;
    logic [2:0]  ps_mode;
    logic        busy;
    logic        en_ts;
    logic        en_adc;
    logic        soc_ts;
    logic [5:0]  bjt_sel;
    logic [3:0]  sel;
    logic        soc_ps;
    logic [2:0]  en_ps;
    logic        eoc_ts;
    logic        eoc_ps;
    logic [11:0] data_ts;
    logic [11:0] data_ps;
    logic        res_valid;
    logic [6:0]  res_idx;
    logic [11:0] res_data;
    logic        res_timeout;
    logic        sweep_done;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    anchor   = 0;
    chan_t exp_q[$];

    pvt_sweep_ctrl #(
        .NUM_TS_PROBES (NUM_TS),
        .NUM_VOL       (NUM_VOL),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_continuous      (continuous),
        .i_abort           (abort_req),
        .i_ps_mode         (ps_mode),
        .o_busy            (busy),
        .o_pvt_en_ts       (en_ts),
        .o_pvt_en_adc_ts   (en_adc),
        .o_pvt_soc_ts      (soc_ts),
        .o_pvt_bjt_sel_ts  (bjt_sel),
        .o_pvt_sel_ts      (sel),
        .o_pvt_soc_ps      (soc_ps),
        .o_pvt_en_ps       (en_ps),
        .i_pvt_eoc_ts      (eoc_ts),
        .i_pvt_eoc_ps      (eoc_ps),
        .i_pvt_out_12bit_ts(data_ts),
        .i_pvt_out_12bit_ps(data_ps),
        .o_res_valid       (res_valid),
        .o_res_idx         (res_idx),
        .o_res_data        (res_data),
        .o_res_timeout     (res_timeout),
        .o_sweep_done      (sweep_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Expected channel list for one sweep.
    function automatic void build_chans(input int mode);
        exp_q.delete();
        for (int i = 0; i < int'(NUM_TS); i++) exp_q.push_back('{i, i, 0, 0, 1'b0});
        for (int v = 1; v <= int'(NUM_VOL); v++) exp_q.push_back('{int'(NUM_TS) + v - 1, 0, v, 0, 1'b0});
        if (mode != 0) exp_q.push_back('{int'(NUM_TS + NUM_VOL), 0, 0, mode, 1'b1});
    endfunction

    function automatic logic [31:0] ctrl_vec();
        return 32'({busy, en_ts, en_adc, soc_ts, soc_ps, bjt_sel, sel, en_ps, res_valid, sweep_done});
    endfunction

    task automatic idle_watch(input int n, input string tag);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (busy || soc_ts || soc_ps || res_valid || sweep_done) act++;
        end
        chk(tag, 32'(act), 32'd0);
    endtask

    task automatic run_sweep(input int mode, input bit launch, input bit cont_next, input int next_mode,
                             input int to_idx, input int held_idx, input int abort_idx, input bit fixed);
        int          s;
        int          d;
        int          exp_k;
        int          early;
        int          nch;
        bit          tmo;
        bit          held;
        logic [11:0] val;
        chan_t       c;
        build_chans(mode);
        nch = exp_q.size();
        if (launch) begin
            ps_mode = 3'(mode);
            start   = 1'b1;
            anchor  = cyc;
            tick();
            start = 1'b0;
            chk("launch_busy", 32'({busy, en_ts, en_adc}), 32'h7);
        end
        for (int ch = 0; ch < nch; ch++) begin
            c    = exp_q[ch];
            held = (ch == held_idx);
            tmo  = held || (ch == to_idx) || (ch == abort_idx);
            if (held) begin
                if (c.ps) eoc_ps = 1'b1;
                else eoc_ts = 1'b1;
            end
            while (!(soc_ts || soc_ps) && (cyc - anchor) < int'(SETTLE) + 8) tick();
            if (!(soc_ts || soc_ps)) begin
                chk("soc_seen", 32'd0, 32'd1);
                return;
            end
            s = cyc;
            chk("soc_gap", 32'(s - anchor), 32'(SETTLE + 1));
            chk("soc_kind", 32'({soc_ts, soc_ps}), c.ps ? 32'd1 : 32'd2);
            chk("mux", 32'({bjt_sel, sel, en_ps}), 32'({6'(c.bjt), 4'(c.sel), 3'(c.en_ps)}));
            chk("enables", 32'({busy, en_ts, en_adc}), 32'h7);
            if (ch == 0) begin
                continuous = cont_next;
                ps_mode    = 3'(next_mode);
            end
            d     = fixed ? 20 : int'($urandom_range(40, 2));
            val   = fixed ? 12'(256 + c.idx) : 12'($urandom);
            exp_k = tmo ? int'(TIMEOUT) + 1 : d + 1;
            early = 0;
            for (int k = 1; k <= exp_k; k++) begin
                tick();
                if (k < exp_k && (res_valid || sweep_done)) early++;
                if (soc_ts || soc_ps) early++;
                if (ch == abort_idx && k == 6) begin
                    abort_req = 1'b0;
                    chk("abort_idle", 32'({busy, en_ts, en_adc}), 32'd0);
                    chk("abort_no_early", 32'(early), 32'd0);
                    idle_watch(int'(TIMEOUT) + 40, "abort_quiet");
                    return;
                end
                start = (ch == 1 && k == 1);
                // Pulse the unrelated EOC bus; the sequencer must ignore it.
                if (c.ps) eoc_ts = (k == 1);
                else eoc_ps = (k == 1);
                if (k == 1) begin
                    if (c.ps) data_ts = 12'($urandom);
                    else data_ps = 12'($urandom);
                end
                if (!tmo && k == d) begin
                    if (c.ps) begin eoc_ps = 1'b1; data_ps = val; end
                    else begin eoc_ts = 1'b1; data_ts = val; end
                end
                if (!tmo && k == d + 1) begin
                    if (c.ps) eoc_ps = 1'b0;
                    else eoc_ts = 1'b0;
                end
                if (ch == abort_idx && k == 5) abort_req = 1'b1;
            end
            chk("res_strobe", 32'({res_valid, sweep_done}), 32'd2);
            chk("res_idx", 32'(res_idx), 32'(c.idx));
            chk("res_data", 32'(res_data), tmo ? 32'd0 : 32'(val));
            chk("res_timeout", 32'(res_timeout), 32'(tmo));
            chk("no_early", 32'(early), 32'd0);
            if (held) begin
                eoc_ts = 1'b0;
                eoc_ps = 1'b0;
            end
            anchor = cyc;
        end
        tick();
        chk("sweep_done", 32'({sweep_done, res_valid}), 32'd2);
        anchor = cyc;
        if (!cont_next) begin
            tick();
            chk("idle_after_done", 32'({busy, en_ts, en_adc, sweep_done}), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        abort_req  = 1'b0;
        ps_mode    = 3'd0;
        eoc_ts     = 1'b0;
        eoc_ps     = 1'b0;
        data_ts    = '0;
        data_ps    = '0;
        repeat (3) tick();
        chk("reset_ctrl", ctrl_vec(), 32'd0);
        chk("reset_res", 32'({res_idx, res_data, res_timeout}), 32'd0);
        rst_n = 1'b1;
        idle_watch(5, "idle_after_reset");

        run_sweep(0, 1'b1, 1'b0, 0, -1, -1, -1, 1'b1);
        run_sweep(5, 1'b1, 1'b0, 0, 2, 4, -1, 1'b0);
        run_sweep(3, 1'b1, 1'b1, 0, -1, -1, -1, 1'b0);
        run_sweep(0, 1'b0, 1'b0, 0, -1, -1, -1, 1'b0);
        run_sweep(0, 1'b1, 1'b0, 0, -1, -1, 5, 1'b0);

        // Start coincident with abort is dropped.
        start     = 1'b1;
        abort_req = 1'b1;
        tick();
        start     = 1'b0;
        abort_req = 1'b0;
        chk("start_abort_busy", 32'({busy, en_ts, en_adc}), 32'd0);
        idle_watch(25, "start_abort_quiet");

        // Asynchronous reset while waiting for EOC.
        ps_mode = 3'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(SETTLE) + 8 && !soc_ts; i++) tick();
        chk("pre_reset_soc", 32'(soc_ts), 32'd1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", ctrl_vec(), 32'd0);
        tick();
        rst_n = 1'b1;
        idle_watch(40, "post_reset_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
